// File: rtl/rapid_pkg.sv
// Shared execute-side types: datapath width, decoded control bundle and the
// issue scheduler state encoding.
package rapid_pkg;

    localparam int XLEN                  = 32;
    localparam int SCHED_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       is_branch;
        logic       is_jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } control_s;

    function automatic control_s control_s_default();
        control_s c;
        c = '0;
        return c;
    endfunction

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_HOLD  = 3'd1,
        SCH_ISSUE = 3'd2,
        SCH_BUSY  = 3'd3,
        SCH_FLUSH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/ex_scoreboard.sv
// Per-register pending-write bitmask with set-over-clear priority and a
// two-port read-after-write hazard lookup. Register 0 is never tracked.
module ex_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic              rs1_used_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              rs2_used_i,
    output logic              hazard_o
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            rs1_hit;
    logic            rs2_hit;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i && (set_addr_i != '0)) begin
            set_mask[set_addr_i] = 1'b1;
        end
        if (clr_en_i) begin
            clr_mask[clr_addr_i] = 1'b1;
        end
        // A retiring write and a new issue to the same register leave it pending.
        sb_d = (sb_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rs1_hit  = rs1_used_i && (rs1_addr_i != '0) && sb_q[rs1_addr_i];
    assign rs2_hit  = rs2_used_i && (rs2_addr_i != '0) && sb_q[rs2_addr_i];
    assign hazard_o = rs1_hit || rs2_hit;

endmodule

// File: rtl/ex_issue_scheduler.sv
// Single-entry issue buffer in front of execute_stage: RAW stall, issue pulse,
// done/redirect handling and watchdog. Optional EX_SCHED_PERF_COUNTERS_EN
// adds issue and stall counters.
module ex_issue_scheduler
    import rapid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEFAULT,
    parameter int REG_AW         = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [XLEN-1:0]   i_id_rs1,
    input  logic [XLEN-1:0]   i_id_rs2,
    input  logic [XLEN-1:0]   i_id_imm,
    input  control_s          i_id_control,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic              i_id_rd_write,
    output logic              o_ex_pipeline_ready,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1,
    output logic [XLEN-1:0]   o_ex_rs2,
    output logic [XLEN-1:0]   o_ex_imm,
    output control_s          o_ex_control,
    input  logic              i_ex_done,
    input  logic              i_ex_pc_load,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    output logic              o_flush,
    output logic              o_timeout,
    output sched_state_t      o_state
`ifdef EX_SCHED_PERF_COUNTERS_EN
    ,
    output logic [31:0]       o_issue_count,
    output logic [31:0]       o_stall_count
`endif
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t      state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    control_s          ctrl_q;
    logic [REG_AW-1:0] rs1a_q, rs2a_q, rda_q;
    logic              rs1u_q, rs2u_q, rdw_q;

    logic              done_ok;
    logic              accept;
    logic              issue;
    logic              hazard;
    logic [REG_AW-1:0] lk_rs1_addr, lk_rs2_addr;
    logic              lk_rs1_used, lk_rs2_used;

    assign done_ok    = (state_q == SCH_BUSY) && i_ex_done;
    assign o_id_ready = (state_q == SCH_IDLE) || (done_ok && !i_ex_pc_load);
    assign accept     = i_id_valid && o_id_ready;
    assign issue      = (state_q == SCH_ISSUE);

    // HOLD re-checks the buffered operands; otherwise the incoming ones are checked.
    always_comb begin
        if (state_q == SCH_HOLD) begin
            lk_rs1_addr = rs1a_q;
            lk_rs2_addr = rs2a_q;
            lk_rs1_used = rs1u_q;
            lk_rs2_used = rs2u_q;
        end else begin
            lk_rs1_addr = i_id_rs1_addr;
            lk_rs2_addr = i_id_rs2_addr;
            lk_rs1_used = i_id_rs1_used;
            lk_rs2_used = i_id_rs2_used;
        end
    end

    ex_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk_i      (i_clk),
        .rst_ni     (i_reset_n),
        .set_en_i   (issue && rdw_q),
        .set_addr_i (rda_q),
        .clr_en_i   (i_wb_valid),
        .clr_addr_i (i_wb_rd_addr),
        .rs1_addr_i (lk_rs1_addr),
        .rs1_used_i (lk_rs1_used),
        .rs2_addr_i (lk_rs2_addr),
        .rs2_used_i (lk_rs2_used),
        .hazard_o   (hazard)
    );

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        unique case (state_q)
            SCH_IDLE: begin
                if (accept) begin
                    state_d = hazard ? SCH_HOLD : SCH_ISSUE;
                end
            end
            SCH_HOLD: begin
                if (!hazard) begin
                    state_d = SCH_ISSUE;
                end
            end
            SCH_ISSUE: begin
                state_d = SCH_BUSY;
                wd_d    = '0;
            end
            SCH_BUSY: begin
                if (i_ex_done) begin
                    if (i_ex_pc_load) begin
                        state_d = SCH_FLUSH;
                    end else if (accept) begin
                        state_d = hazard ? SCH_HOLD : SCH_ISSUE;
                    end else begin
                        state_d = SCH_IDLE;
                    end
                // wd_q counts completed BUSY cycles; this one is number TIMEOUT_CYCLES.
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = SCH_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            SCH_FLUSH: state_d = SCH_IDLE;
            default:   state_d = SCH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= SCH_IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            ctrl_q <= control_s_default();
            rs1a_q <= '0;
            rs2a_q <= '0;
            rda_q  <= '0;
            rs1u_q <= 1'b0;
            rs2u_q <= 1'b0;
            rdw_q  <= 1'b0;
        end else if (accept) begin
            pc_q   <= i_id_pc;
            rs1_q  <= i_id_rs1;
            rs2_q  <= i_id_rs2;
            imm_q  <= i_id_imm;
            ctrl_q <= i_id_control;
            rs1a_q <= i_id_rs1_addr;
            rs2a_q <= i_id_rs2_addr;
            rda_q  <= i_id_rd_addr;
            rs1u_q <= i_id_rs1_used;
            rs2u_q <= i_id_rs2_used;
            rdw_q  <= i_id_rd_write;
        end
    end

`ifdef EX_SCHED_PERF_COUNTERS_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (state_q == SCH_HOLD) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_issue_count = issue_cnt_q;
    assign o_stall_count = stall_cnt_q;
`endif

    assign o_ex_pipeline_ready = issue;
    assign o_ex_pc             = pc_q;
    assign o_ex_rs1            = rs1_q;
    assign o_ex_rs2            = rs2_q;
    assign o_ex_imm            = imm_q;
    assign o_ex_control        = ctrl_q;
    assign o_flush             = (state_q == SCH_FLUSH);
    assign o_timeout           = timeout_q;
    assign o_state             = state_q;

endmodule

// File: doc/ex_issue_scheduler.md
# ex_issue_scheduler

Sequences the execute stage. It accepts decoded instructions from decode over a valid/ready handshake and holds one instruction in an issue buffer. A per-register scoreboard stalls read-after-write hazards. The block issues to `execute_stage` with a one-cycle `i_pipeline_ready` pulse, waits for `o_done`, and flushes wrong-path work when a taken branch or jump returns `o_pc_load`. It sits between decode/register-read and `execute_stage`.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles from issue to `i_ex_done` before the watchdog trips.
- `REG_AW`, default 5: register address width; the scoreboard holds 2**REG_AW bits.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_id_valid`  in  1  decode payload valid.
- `o_id_ready`  out  1  scheduler accepts the payload.
- `i_id_pc`, `i_id_rs1`, `i_id_rs2`, `i_id_imm`  in  XLEN each  payload data.
- `i_id_control`  in  control_s  payload control.
- `i_id_rs1_addr`, `i_id_rs2_addr`, `i_id_rd_addr`  in  REG_AW each  register addresses.
- `i_id_rs1_used`, `i_id_rs2_used`, `i_id_rd_write`  in  1 each  operand and writeback qualifiers.
- `o_ex_pipeline_ready`  out  1  issue pulse to execute.
- `o_ex_pc`, `o_ex_rs1`, `o_ex_rs2`, `o_ex_imm`  out  XLEN each  issued payload.
- `o_ex_control`  out  control_s  issued control.
- `i_ex_done`  in  1  execute completed.
- `i_ex_pc_load`  in  1  redirect; sampled only when `i_ex_done` is high.
- `i_wb_valid`  in  1  register write retired.
- `i_wb_rd_addr`  in  REG_AW  address of the retired register.
- `o_flush`  out  1  one-cycle pulse telling fetch/decode to drop wrong-path work.
- `o_timeout`  out  1  sticky watchdog error.
- `o_state`  out  sched_state_t  current state, for verification only.

## Operation
- States:
  - SCH_IDLE: the buffer is empty and `o_id_ready` is 1.
  - SCH_HOLD: the buffer is full but the instruction is hazarded.
  - SCH_ISSUE: `o_ex_pipeline_ready` is 1.
  - SCH_BUSY: waiting for `i_ex_done`.
  - SCH_FLUSH: the buffer is dropped and `o_flush` is 1.
- Transitions:
  - IDLE goes to ISSUE on `i_id_valid` when there is no hazard, or to HOLD when there is one.
  - HOLD goes to ISSUE once the hazard clears.
  - ISSUE always goes to BUSY.
  - BUSY:
    - On `i_ex_done` with `i_ex_pc_load` it goes to FLUSH.
    - On `i_ex_done` without `i_ex_pc_load` it goes to IDLE.
    - The exception is a new accept in the same cycle (see back-to-back below), in which case it goes to ISSUE or HOLD.
  - FLUSH always goes to IDLE.
- Hazard: `(rs1_used & sb[rs1_addr]) | (rs2_used & sb[rs2_addr])`.
  - Address 0 is never hazarded.
  - The check is evaluated on the buffered instruction every cycle in HOLD.
- Scoreboard:
  - The bit for rd is set in the ISSUE cycle when `rd_write` is 1 and rd != 0.
  - A bit is cleared on `i_wb_valid` for `i_wb_rd_addr`.
  - If set and clear hit the same register in the same cycle, set wins.
  - A flush does not clear scoreboard bits. Only instructions that were already issued are ever set, and they retire normally.
- Back-to-back: `o_id_ready` is also 1 in BUSY when `i_ex_done` is 1 and `i_ex_pc_load` is 0. An instruction accepted in that cycle enters ISSUE or HOLD directly.
- `o_ex_*` payload registers load on accept. They are held stable from ISSUE through the `i_ex_done` cycle.
- Watchdog:
  - A counter clears in ISSUE and increments in BUSY.
  - When it reaches TIMEOUT_CYCLES, `o_timeout` is set and the state is forced to IDLE.
  - `o_timeout` clears only on reset.

## Timing
- Reset values:
  - State is SCH_IDLE, so `o_id_ready` is 1.
  - `o_ex_pipeline_ready`, `o_flush` and `o_timeout` are 0.
  - `o_ex_*` data is 0 and `o_ex_control` is control_s_default().
  - The scoreboard is all 0.
- Unhazarded instruction:
  - Accepted at cycle N.
  - Issue pulse at N+1.
  - `i_ex_done` expected at N+2 (execute_stage WAIT→EXECUTE).
  - Next issue possible at N+3.
  - Sustained rate is one instruction per 2 cycles.
- Redirect: `i_ex_done` with `i_ex_pc_load` at cycle M gives `o_flush` at M+1 and `o_id_ready` at M+2.
- `o_id_ready` is low during FLUSH. Any decode valid presented in FLUSH is ignored.
- Reset asserted mid-BUSY returns the block to IDLE immediately. Pending done/writeback inputs are ignored until reset is deasserted.
- `i_ex_done` outside BUSY is ignored.

## Configuration
- Macro `EX_SCHED_PERF_COUNTERS_EN`.
  - When defined, it adds output `o_issue_count` (32 bits, increments on each ISSUE).
  - It also adds output `o_stall_count` (32 bits, increments on each HOLD cycle).
  - Both counters reset to 0 and wrap at 2**32.
  - When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- `rapid_pkg` holds `sched_state_t` (SCH_IDLE, SCH_HOLD, SCH_ISSUE, SCH_BUSY, SCH_FLUSH).
- `rapid_pkg` also holds `SCHED_TIMEOUT_DEFAULT`. It reuses the existing `XLEN`, `control_s` and `control_s_default()`.
- Sub-module `ex_scoreboard` holds the bitmask, performs set/clear with set-priority, and provides the two-port hazard lookup.

## Test plan
- Reset, then ADDI x5 (`rd_write`=1): `o_id_ready` is 1 after reset; issue pulse one cycle after accept; `sb[5]` is 1 until `i_wb_valid` with rd=5.
- ADD x6,x5,x1 while `sb[5]` is 1: the block holds in SCH_HOLD and `o_ex_pipeline_ready` stays 0. Writeback of x5 at cycle K gives issue at K+2.
- BEQ done with `i_ex_pc_load`=1: `o_flush` pulses one cycle, the buffered instruction is never issued, and `o_id_ready` is 0 during FLUSH.
- Rd=0 writes never set the scoreboard. A same-cycle set and clear of x7 leaves `sb[7]` at 1.
- `i_ex_done` withheld for 16 cycles: `o_timeout` is 1, the state returns to IDLE, and `o_timeout` stays 1 until reset.
- With `EX_SCHED_PERF_COUNTERS_EN` defined: 3 issues with 4 hazard cycles give `o_issue_count`=3 and `o_stall_count`=4.
